cache_nway: RTL and testbench

CACHE_NWAY -- requirements
Module: cache_nway

---
 rtl/cache_nway.sv | 187 ++++++++++++++++++
 tb/tb_cache_nway.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_nway.sv
// N-way set-associative write-back cache with true-LRU replacement and a blocking memory handshake.
// Optional hit/miss/write-back counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_nway #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt,
    output logic [31:0]  wb_cnt
`endif
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int SET_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = 28 - SET_BITS;
    localparam logic [WAY_BITS-1:0] OLDEST = WAY_BITS'(NUM_WAYS - 1);

    typedef enum logic [1:0] {IDLE, COMP, WRITE, ALLOC} state_t;

    state_t state;

    logic                valid [NUM_WAYS][NUM_SETS];
    logic                dirty [NUM_WAYS][NUM_SETS];
    logic [TAG_BITS-1:0] tags  [NUM_WAYS][NUM_SETS];
    logic [127:0]        data  [NUM_WAYS][NUM_SETS];
    logic [WAY_BITS-1:0] age   [NUM_WAYS][NUM_SETS];
    logic [WAY_BITS-1:0] victim;

    logic [1:0]          word_sel;
    logic [SET_BITS-1:0] set_idx;
    logic [TAG_BITS-1:0] tag_in;
    logic                req;

    assign word_sel = proc_addr[1:0];
    assign set_idx  = proc_addr[SET_BITS+1:2];
    assign tag_in   = proc_addr[29:SET_BITS+2];
    assign req      = proc_read | proc_write;

    logic [WAY_BITS:0]   match_cnt;
    logic [WAY_BITS-1:0] match_way;
    logic                hit;
    logic [127:0]        hit_line;
    logic [31:0]         hit_word;

    // A hit needs exactly one matching valid way; anything else is treated as a miss.
    always_comb begin
        match_cnt = '0;
        match_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid[w][set_idx] && (tags[w][set_idx] == tag_in)) begin
                match_cnt = match_cnt + (WAY_BITS+1)'(1);
                match_way = WAY_BITS'(w);
            end
        end
        hit      = (state == COMP) && (match_cnt == (WAY_BITS+1)'(1));
        hit_line = data[match_way][set_idx];
        hit_word = hit_line[{word_sel, 5'b00000} +: 32];
    end

    logic [WAY_BITS-1:0] victim_next;
    logic                found_invalid;

    always_comb begin
        victim_next   = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_invalid && !valid[w][set_idx]) begin
                victim_next   = WAY_BITS'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age[w][set_idx] == OLDEST) begin
                    victim_next = WAY_BITS'(w);
                end
            end
        end
    end

    always_comb begin
        proc_stall = req && !hit;
        proc_rdata = (proc_read && hit) ? hit_word : 32'd0;
        mem_read   = (state == ALLOC) && !mem_ready;
        mem_write  = (state == WRITE) && !mem_ready;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (state == WRITE) begin
            mem_addr  = {tags[victim][set_idx], set_idx};
            mem_wdata = data[victim][set_idx];
        end else if (state == ALLOC) begin
            mem_addr = proc_addr[29:2];
        end
    end

    // A freshly filled way is marked oldest so the retry hit promotes it and ages every
    // other way; this keeps the ages a permutation once all ways have been filled from reset.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state  <= IDLE;
            victim <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    valid[w][s] <= 1'b0;
                    dirty[w][s] <= 1'b0;
                    tags[w][s]  <= '0;
                    data[w][s]  <= '0;
                    age[w][s]   <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: state <= COMP;
                COMP: begin
                    if (req && hit) begin
                        if (proc_write) begin
                            data[match_way][set_idx][{word_sel, 5'b00000} +: 32] <= proc_wdata;
                            dirty[match_way][set_idx] <= 1'b1;
                        end
                        for (int w = 0; w < NUM_WAYS; w++) begin
                            if (WAY_BITS'(w) == match_way) begin
                                age[w][set_idx] <= '0;
                            end else if (age[w][set_idx] < age[match_way][set_idx]) begin
                                age[w][set_idx] <= age[w][set_idx] + WAY_BITS'(1);
                            end
                        end
                    end else if (req) begin
                        victim <= victim_next;
                        if (valid[victim_next][set_idx] && dirty[victim_next][set_idx]) begin
                            state <= WRITE;
                        end else begin
                            state <= ALLOC;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        dirty[victim][set_idx] <= 1'b0;
                        state <= ALLOC;
                    end
                end
                ALLOC: begin
                    if (mem_ready) begin
                        data[victim][set_idx]  <= mem_rdata;
                        tags[victim][set_idx]  <= tag_in;
                        valid[victim][set_idx] <= 1'b1;
                        dirty[victim][set_idx] <= 1'b0;
                        age[victim][set_idx]   <= OLDEST;
                        state <= COMP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (req && hit) hit_cnt <= hit_cnt + 32'd1;
            if ((state == COMP) && req && !hit) miss_cnt <= miss_cnt + 32'd1;
            if ((state == WRITE) && mem_ready) wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: directed scenarios plus random accesses against a
// word-level memory model and a recency-stamp model of cache residency.
module tb_cache_nway;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 8;
    localparam int SET_BITS = 3;
    localparam int MAX_CYC  = 60;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    cache_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    // Reference state: word-level truth, backing store seen by the DUT, and residency per set.
    logic [31:0]  ref_word [logic [29:0]];
    logic [127:0] bmem     [logic [27:0]];
    bit           m_valid  [NUM_SETS][NUM_WAYS];
    bit           m_dirty  [NUM_SETS][NUM_WAYS];
    logic [24:0]  m_tag    [NUM_SETS][NUM_WAYS];
    int unsigned  last_use [NUM_SETS][NUM_WAYS];
    int unsigned  stamp = 0;
    int           exp_hits = 0, exp_misses = 0, exp_wbs = 0;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] get_word(input logic [29:0] a);
        if (ref_word.exists(a)) return ref_word[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] ref_block(input logic [27:0] b);
        return {get_word({b, 2'd3}), get_word({b, 2'd2}), get_word({b, 2'd1}), get_word({b, 2'd0})};
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] b);
        if (bmem.exists(b)) return bmem[b];
        return {init_word({b, 2'd3}), init_word({b, 2'd2}), init_word({b, 2'd1}), init_word({b, 2'd0})};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic clearModel();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_valid[s][w]  = 1'b0;
                m_dirty[s][w]  = 1'b0;
                m_tag[s][w]    = '0;
                last_use[s][w] = 0;
            end
        end
        exp_hits = 0; exp_misses = 0; exp_wbs = 0;
    endtask

    task automatic checkCounters();
`ifdef CACHE_PERF_CNT_EN
        checkOutput("hit_cnt", hit_cnt, exp_hits);
        checkOutput("miss_cnt", miss_cnt, exp_misses);
        checkOutput("wb_cnt", wb_cnt, exp_wbs);
`endif
    endtask

    // Reset for one edge, then check the IDLE cycle before the cache enters COMP.
    task automatic doReset();
        @(negedge clk);
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        #1;
        checkOutput("rst_mem_read", mem_read, 1'b0);
        checkOutput("rst_mem_write", mem_write, 1'b0);
        checkOutput("rst_stall_noreq", proc_stall, 1'b0);
        checkOutput("rst_rdata", proc_rdata, 32'd0);
        proc_read = 1'b1;
        #1;
        checkOutput("idle_stall_req", proc_stall, 1'b1);
        proc_read = 1'b0;
        clearModel();
        @(negedge clk);
        checkCounters();
    endtask

    // One processor access with a memory responder of latency lat, checked against the model.
    task automatic applyStimulus(input bit rd, input bit wr, input logic [29:0] a,
                                 input logic [31:0] wd, input int lat);
        int s_idx, hit_w, victim, w_use, stalls, wait_cnt, wb_seen, rd_seen, exp_stalls;
        bit exp_miss, exp_wb, done, both, mem_busy_done;
        logic [24:0]  tag;
        logic [27:0]  exp_wb_addr, wb_addr, rd_addr;
        logic [127:0] exp_wb_data, wb_data;
        logic [31:0]  exp_rdata, obs_rdata;
        int unsigned  best;

        s_idx = int'(a[SET_BITS+1:2]);
        tag   = a[29:SET_BITS+2];
        hit_w = -1;
        for (int w = 0; w < NUM_WAYS; w++)
            if (m_valid[s_idx][w] && m_tag[s_idx][w] == tag) hit_w = w;
        exp_miss = (hit_w < 0);
        exp_wb = 1'b0; victim = -1; exp_wb_addr = '0; exp_wb_data = '0;
        if (exp_miss) begin
            for (int w = 0; w < NUM_WAYS; w++)
                if (victim < 0 && !m_valid[s_idx][w]) victim = w;
            if (victim < 0) begin
                best = 32'hFFFF_FFFF;
                for (int w = 0; w < NUM_WAYS; w++)
                    if (last_use[s_idx][w] < best) begin best = last_use[s_idx][w]; victim = w; end
            end
            exp_wb = m_valid[s_idx][victim] && m_dirty[s_idx][victim];
            exp_wb_addr = {m_tag[s_idx][victim], 3'(s_idx)};
            exp_wb_data = ref_block(exp_wb_addr);
        end
        exp_rdata  = rd ? get_word(a) : 32'd0;
        exp_stalls = exp_miss ? (1 + (exp_wb ? lat + 1 : 0) + lat + 1) : 0;

        proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd; mem_ready = 1'b0;
        stalls = 0; wait_cnt = 0; wb_seen = 0; rd_seen = 0; done = 1'b0; both = 1'b0;
        mem_busy_done = 1'b0; obs_rdata = '0; wb_addr = '0; wb_data = '0; rd_addr = '0;
        for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
            #1;
            if (mem_read && mem_write) both = 1'b1;
            if (!proc_stall) begin
                done = 1'b1;
                obs_rdata = proc_rdata;
                mem_busy_done = mem_read | mem_write;
            end else begin
                stalls++;
                if (mem_read || mem_write) begin
                    if (wait_cnt >= lat) begin
                        if (mem_write) begin
                            wb_seen++; wb_addr = mem_addr; wb_data = mem_wdata;
                            bmem[mem_addr] = mem_wdata;
                        end else begin
                            rd_seen++; rd_addr = mem_addr; mem_rdata = mem_block(mem_addr);
                        end
                        mem_ready = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
        @(negedge clk);
        proc_read = 1'b0; proc_write = 1'b0;

        checkOutput("done", done, 1'b1);
        checkOutput("rdata", obs_rdata, exp_rdata);
        checkOutput("stall_cycles", stalls, exp_stalls);
        checkOutput("wb_count", wb_seen, exp_wb);
        if (exp_wb && wb_seen == 1) begin
            checkOutput("wb_addr", wb_addr, exp_wb_addr);
            checkOutput("wb_data", wb_data, exp_wb_data);
        end
        checkOutput("fill_count", rd_seen, exp_miss);
        if (exp_miss && rd_seen == 1) checkOutput("fill_addr", rd_addr, a[29:2]);
        checkOutput("no_both", both, 1'b0);
        checkOutput("mem_idle_done", mem_busy_done, 1'b0);

        if (exp_miss) begin
            m_valid[s_idx][victim] = 1'b1;
            m_tag[s_idx][victim]   = tag;
            m_dirty[s_idx][victim] = 1'b0;
            w_use = victim;
            exp_misses++;
            if (exp_wb) exp_wbs++;
        end else begin
            w_use = hit_w;
        end
        stamp++;
        last_use[s_idx][w_use] = stamp;
        if (wr) begin
            m_dirty[s_idx][w_use] = 1'b1;
            ref_word[a] = wd;
        end
        exp_hits++;
    endtask

    initial begin
        logic [29:0] a;
        doReset();

        $display("[TB] cold miss, write hit, read back");
        applyStimulus(1'b1, 1'b0, 30'h10, 32'd0, 1);
        applyStimulus(1'b0, 1'b1, 30'h11, 32'hDEADBEEF, 0);
        applyStimulus(1'b1, 1'b0, 30'h11, 32'd0, 0);
        applyStimulus(1'b1, 1'b1, 30'h11, 32'h1234_5678, 0);
        checkCounters();

        $display("[TB] set 0 fill, LRU eviction, dirty write-back");
        for (int t = 1; t <= 5; t++) applyStimulus(1'b1, 1'b0, 30'(t << 5), 32'd0, 1);
        applyStimulus(1'b1, 1'b0, 30'(3 << 5), 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 30'(1 << 5), 32'd0, 2);
        applyStimulus(1'b0, 1'b1, 30'((3 << 5) | 2), 32'hCAFE_F00D, 0);
        applyStimulus(1'b1, 1'b0, 30'(4 << 5), 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 30'(5 << 5), 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 30'(1 << 5), 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 30'(6 << 5), 32'd0, 2);
        applyStimulus(1'b1, 1'b0, 30'((3 << 5) | 2), 32'd0, 1);
        checkCounters();

        $display("[TB] reset during ALLOC");
        proc_read = 1'b1; proc_addr = 30'(9 << 5); mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("alloc_mem_read", mem_read, 1'b1);
        doReset();
        applyStimulus(1'b1, 1'b0, 30'h10, 32'd0, 0);

        $display("[TB] random accesses");
        for (int i = 0; i < 200; i++) begin
            bit rd, wr;
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = {25'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            applyStimulus(rd, wr, a, $urandom, $urandom_range(0, 2));
        end
        checkCounters();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
